// File: rtl/core_pkg.sv
// Shared definitions for the core writeback slice: load funct3 encodings,
// writeback FSM states and error codes.
package core_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_SPURIOUS = 2'b10,
        ERR_FUNCT3   = 2'b11
    } wb_err_e;

endpackage

// File: rtl/core_load_align.sv
// Load data alignment: selects the addressed byte/half of the raw memory word
// and sign- or zero-extends it to XLEN.
module core_load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic            bad_funct3
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        byte_sel   = rdata[7:0];
        half_sel   = rdata[15:0];
        wdata      = '0;
        bad_funct3 = 1'b0;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // addr_lo[0] is don't-care for halfwords; misalignment is trapped upstream.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            LB:      wdata = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU:     wdata = {{(XLEN-8){1'b0}}, byte_sel};
            LH:      wdata = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU:     wdata = {{(XLEN-16){1'b0}}, half_sel};
            LW:      wdata = rdata;
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_wb.sv
// Writeback stage: retires instructions from MEM into the register file,
// waits for load responses, counts retirements and latches the first protocol error.
module core_wb
    import core_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_sync,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_funct3,
    input  logic [1:0]        mem_addr_lo,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [XLEN-1:0]   reg_wdata,
    output logic              reg_wen,
    output logic              stall_n,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              wb_err,
    output logic [1:0]        wb_err_code
);

    localparam logic ST_IDLE      = IDLE;
    localparam logic ST_WAIT_LOAD = WAIT_LOAD;
    localparam int   TW           = $clog2(LOAD_TIMEOUT + 1);

    logic              state;
    logic [TW-1:0]     tcnt;
    logic [REG_AW-1:0] ld_rd;
    logic              ld_wen;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_addr_lo;

    logic [XLEN-1:0]   align_wdata;
    logic              bad_funct3;
    logic              load_timeout;
    logic              err_hit;
    wb_err_e           err_nxt;

    core_load_align #(.XLEN(XLEN)) u_align (
        .funct3     (ld_funct3),
        .addr_lo    (ld_addr_lo),
        .rdata      (dmem_rdata),
        .wdata      (align_wdata),
        .bad_funct3 (bad_funct3)
    );

    assign mem_ready    = (state == ST_IDLE) && !rst_sync;
    assign stall_n      = mem_ready;
    assign load_timeout = (state == ST_WAIT_LOAD) && !dmem_rvalid
                          && (tcnt == TW'(LOAD_TIMEOUT - 1));

    // A response that wins the race against the timeout is checked for funct3 instead.
    always_comb begin
        err_hit = 1'b0;
        err_nxt = ERR_NONE;
        if (state == ST_IDLE && dmem_rvalid) begin
            err_hit = 1'b1;
            err_nxt = ERR_SPURIOUS;
        end else if (state == ST_WAIT_LOAD) begin
            if (dmem_rvalid && bad_funct3) begin
                err_hit = 1'b1;
                err_nxt = ERR_FUNCT3;
            end else if (load_timeout) begin
                err_hit = 1'b1;
                err_nxt = ERR_TIMEOUT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            ld_rd       <= '0;
            ld_wen      <= 1'b0;
            ld_funct3   <= '0;
            ld_addr_lo  <= '0;
            reg_wen     <= 1'b0;
            reg_waddr   <= '0;
            reg_wdata   <= '0;
            retire_cnt  <= '0;
            wb_err      <= 1'b0;
            wb_err_code <= ERR_NONE;
        end else begin
            reg_wen <= 1'b0;

            if (err_hit && !wb_err) begin
                wb_err      <= 1'b1;
                wb_err_code <= err_nxt;
            end

            case (state)
                ST_IDLE: begin
                    if (mem_valid) begin
                        if (mem_is_load) begin
                            ld_rd      <= mem_rd;
                            ld_wen     <= mem_wen;
                            ld_funct3  <= mem_funct3;
                            ld_addr_lo <= mem_addr_lo;
                            tcnt       <= '0;
                            state      <= ST_WAIT_LOAD;
                        end else begin
                            reg_wen    <= mem_wen && (mem_rd != '0);
                            reg_waddr  <= mem_rd;
                            reg_wdata  <= mem_result;
                            retire_cnt <= retire_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_LOAD: begin
                    if (dmem_rvalid || load_timeout) begin
                        reg_wen    <= ld_wen && (ld_rd != '0);
                        reg_waddr  <= ld_rd;
                        reg_wdata  <= dmem_rvalid ? align_wdata : '0;
                        retire_cnt <= retire_cnt + CNT_W'(1);
                        state      <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_wb.sv
// Self-checking bench for core_wb: table of retire vectors plus hand-written
// sequences for timeout, spurious response, bad funct3 and reset during a load.
module tb_core_wb;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic        mem_wen;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic        stall_n;
    logic [31:0] retire_cnt;
    logic        wb_err;
    logic [1:0]  wb_err_code;

    core_wb #(.XLEN(32), .REG_AW(5), .LOAD_TIMEOUT(16), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_sync    (rst_sync),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_wen     (mem_wen),
        .mem_is_load (mem_is_load),
        .mem_funct3  (mem_funct3),
        .mem_addr_lo (mem_addr_lo),
        .mem_result  (mem_result),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .reg_wen     (reg_wen),
        .stall_n     (stall_n),
        .retire_cnt  (retire_cnt),
        .wb_err      (wb_err),
        .wb_err_code (wb_err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic        is_load;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] result;
        logic [31:0] rdata;
        int          dly;
        logic        exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    vec_t        vecs[12];
    int          n_pass  = 0;
    int          n_total = 0;
    int          exp_cnt = 0;
    bit          mon_en  = 1'b0;
    logic [31:0] prev_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Stimulus changes 2 time units after the rising edge; outputs are stable there.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every retirement (retire_cnt step) pops one expected write.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_cnt = retire_cnt;
        end else begin
            if (retire_cnt != prev_cnt) begin
                check("retire_step", retire_cnt, prev_cnt + 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_wen", 32'(reg_wen), 32'(mon_e.wen));
                    check("sb_waddr", 32'(reg_waddr), 32'(mon_e.waddr));
                    check("sb_wdata", reg_wdata, mon_e.wdata);
                end
            end else begin
                check("no_retire_wen", 32'(reg_wen), 0);
            end
            prev_cnt = retire_cnt;
        end
    end

    task automatic push_exp(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
        exp_t e;
        e.wen   = wen;
        e.waddr = waddr;
        e.wdata = wdata;
        exp_q.push_back(e);
        exp_cnt++;
    endtask

    task automatic send(input logic is_load, input logic [2:0] f3, input logic [1:0] alo,
                        input logic [4:0] rd, input logic wen, input logic [31:0] result);
        int g = 0;
        while (!mem_ready && g < 50) begin
            tick();
            g++;
        end
        check("ready_wait", 32'(mem_ready), 1);
        mem_valid   = 1'b1;
        mem_is_load = is_load;
        mem_funct3  = f3;
        mem_addr_lo = alo;
        mem_rd      = rd;
        mem_wen     = wen;
        mem_result  = result;
        tick();
        mem_valid   = 1'b0;
        mem_is_load = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [31:0] rdata);
        repeat (dly - 1) tick();
        check("stall_n_wait", 32'(stall_n), 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        rst_sync = 1'b1;
        tick();
        tick();
        rst_sync = 1'b0;
        exp_q.delete();
        exp_cnt  = 0;
        mon_en   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 2'd0,  5'd0, 1'b1, 32'h0000_1234, 32'h0,          0, 1'b0, 32'h0000_1234};
        vecs[1]  = '{1'b0, 3'b000, 2'd0,  5'd7, 1'b0, 32'h0000_0055, 32'h0,          0, 1'b0, 32'h0000_0055};
        vecs[2]  = '{1'b1, LB,     2'd3,  5'd9, 1'b1, 32'h0,         32'h80FF_0000,  3, 1'b1, 32'hFFFF_FF80};
        vecs[3]  = '{1'b1, LHU,    2'd2, 5'd10, 1'b1, 32'h0,         32'h8001_1234,  1, 1'b1, 32'h0000_8001};
        vecs[4]  = '{1'b1, LW,     2'd1,  5'd0, 1'b1, 32'h0,         32'hCAFE_F00D,  2, 1'b0, 32'hCAFE_F00D};
        vecs[5]  = '{1'b1, LBU,    2'd1, 5'd11, 1'b1, 32'h0,         32'h0000_9A00,  1, 1'b1, 32'h0000_009A};
        vecs[6]  = '{1'b1, LH,     2'd1, 5'd12, 1'b1, 32'h0,         32'h0000_8765,  4, 1'b1, 32'hFFFF_8765};
        vecs[7]  = '{1'b1, LW,     2'd2, 5'd31, 1'b1, 32'h0,         32'h1234_5678,  2, 1'b1, 32'h1234_5678};
        vecs[8]  = '{1'b1, LB,     2'd0,  5'd1, 1'b1, 32'h0,         32'h0000_007F,  1, 1'b1, 32'h0000_007F};
        vecs[9]  = '{1'b1, LH,     2'd3,  5'd2, 1'b1, 32'h0,         32'hF00D_1234,  1, 1'b1, 32'hFFFF_F00D};
        vecs[10] = '{1'b1, LW,     2'd0,  5'd3, 1'b0, 32'h0,         32'hAAAA_5555,  1, 1'b0, 32'hAAAA_5555};
        vecs[11] = '{1'b1, LBU,    2'd2, 5'd14, 1'b1, 32'h0,         32'h00C3_0000,  2, 1'b1, 32'h0000_00C3};

        rst_sync    = 1'b1;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_wen     = 1'b0;
        mem_is_load = 1'b0;
        mem_funct3  = '0;
        mem_addr_lo = '0;
        mem_result  = '0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        repeat (3) tick();

        check("rst_reg_wen", 32'(reg_wen), 0);
        check("rst_reg_waddr", 32'(reg_waddr), 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_retire_cnt", retire_cnt, 0);
        check("rst_wb_err", 32'(wb_err), 0);
        check("rst_err_code", 32'(wb_err_code), 0);
        check("rst_mem_ready", 32'(mem_ready), 0);
        rst_sync = 1'b0;
        #1;
        check("post_rst_stall_n", 32'(stall_n), 1);
        mon_en = 1'b1;

        // ALU retire: write visible the cycle after acceptance.
        push_exp(1'b1, 5'd5, 32'hDEAD_BEEF);
        send(1'b0, 3'b000, 2'd0, 5'd5, 1'b1, 32'hDEAD_BEEF);
        check("alu_reg_wen", 32'(reg_wen), 1);
        check("alu_reg_waddr", 32'(reg_waddr), 5);
        check("alu_reg_wdata", reg_wdata, 32'hDEAD_BEEF);
        check("alu_retire_cnt", retire_cnt, 1);
        drain();

        for (int i = 0; i < 12; i++) begin
            push_exp(vecs[i].exp_wen, vecs[i].rd, vecs[i].exp_wdata);
            send(vecs[i].is_load, vecs[i].f3, vecs[i].alo, vecs[i].rd, vecs[i].wen, vecs[i].result);
            if (vecs[i].is_load) respond(vecs[i].dly, vecs[i].rdata);
            drain();
        end
        check("table_retire_cnt", retire_cnt, 32'(exp_cnt));
        check("table_no_err", 32'(wb_err), 0);

        // Back-to-back ALU accepts: one write per cycle.
        for (int i = 0; i < 3; i++) push_exp(1'b1, 5'(20 + i), 32'h100 + 32'(i));
        mem_valid   = 1'b1;
        mem_is_load = 1'b0;
        mem_wen     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rd     = 5'(20 + i);
            mem_result = 32'h100 + 32'(i);
            check("b2b_ready", 32'(mem_ready), 1);
            tick();
            check("b2b_wen", 32'(reg_wen), 1);
            check("b2b_waddr", 32'(reg_waddr), 32'(20 + i));
        end
        mem_valid = 1'b0;
        drain();

        // Response in the last cycle before timeout is still a normal retire.
        push_exp(1'b1, 5'd6, 32'h0BAD_F00D);
        send(1'b1, LW, 2'd0, 5'd6, 1'b1, 32'h0);
        respond(16, 32'h0BAD_F00D);
        drain();
        check("late_rvalid_no_err", 32'(wb_err), 0);
        check("late_retire_cnt", retire_cnt, 32'(exp_cnt));

        // Spurious response in IDLE: error 10, no write, no retire.
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        tick();
        dmem_rvalid = 1'b0;
        check("spur_err", 32'(wb_err), 1);
        check("spur_code", 32'(wb_err_code), 32'(ERR_SPURIOUS));
        check("spur_cnt", retire_cnt, 32'(exp_cnt));

        // Bad funct3 load after an earlier error: retires with 0, code held.
        push_exp(1'b1, 5'd8, 32'h0);
        send(1'b1, 3'b011, 2'd0, 5'd8, 1'b1, 32'h0);
        respond(1, 32'hFFFF_FFFF);
        drain();
        check("f3_held_code", 32'(wb_err_code), 32'(ERR_SPURIOUS));

        do_reset();
        check("rst2_cnt", retire_cnt, 0);
        check("rst2_code", 32'(wb_err_code), 0);
        push_exp(1'b1, 5'd8, 32'h0);
        send(1'b1, 3'b011, 2'd1, 5'd8, 1'b1, 32'h0);
        respond(2, 32'h7777_7777);
        drain();
        check("f3_code", 32'(wb_err_code), 32'(ERR_FUNCT3));
        check("f3_err", 32'(wb_err), 1);

        // Timeout after exactly 16 waiting cycles: retire with zero data.
        do_reset();
        push_exp(1'b1, 5'd13, 32'h0);
        dmem_rdata = 32'hFFFF_FFFF;
        send(1'b1, LW, 2'd0, 5'd13, 1'b1, 32'h0);
        repeat (15) tick();
        check("to_still_wait", 32'(stall_n), 0);
        check("to_no_err_yet", 32'(wb_err), 0);
        tick();
        check("to_err", 32'(wb_err), 1);
        check("to_code", 32'(wb_err_code), 32'(ERR_TIMEOUT));
        check("to_stall_n", 32'(stall_n), 1);
        check("to_wen", 32'(reg_wen), 1);
        check("to_wdata", reg_wdata, 0);
        drain();
        check("to_cnt", retire_cnt, 1);

        // Reset during WAIT_LOAD: pending load dropped, later rvalid writes nothing.
        do_reset();
        send(1'b1, LW, 2'd0, 5'd4, 1'b1, 32'h0);
        tick();
        check("rmw_waiting", 32'(stall_n), 0);
        mon_en   = 1'b0;
        rst_sync = 1'b1;
        tick();
        check("rmw_ready_in_rst", 32'(mem_ready), 0);
        rst_sync = 1'b0;
        mon_en   = 1'b1;
        #1;
        check("rmw_stall_n", 32'(stall_n), 1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h2222_2222;
        tick();
        dmem_rvalid = 1'b0;
        check("rmw_no_wen", 32'(reg_wen), 0);
        check("rmw_cnt", retire_cnt, 0);
        check("rmw_code", 32'(wb_err_code), 32'(ERR_SPURIOUS));
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
